intersection_phase_controller: RTL and testbench
================================================

INTERSECTION_PHASE_CONTROLLER -- requirements
Module: intersection_phase_controller

Interface
REQ-001 Parameter NUM_APPROACHES, default 2, meaning: number of approaches served round-robin; legal range 2..4.
REQ-002 Parameter CLK_PER_TICK, default 4, meaning: clocks per timing tick.
REQ-003 Parameters LEFT_TICKS 3, GREEN_TICKS 5, YELLOW_TICKS 2, ALL_RED_TICKS 1, PED_TICKS 3, FLASH_TICKS 2, meaning: phase durations in ticks, each >= 1; PED_TICKS <= GREEN_TICKS.
REQ-004 Parameter START_APPROACH, default 0, meaning: first approach served after reset; < NUM_APPROACHES.
REQ-005 in_clock  input  1  sole clock; all logic on rising edge.
REQ-006 in_reset  input  1  synchronous, active-high reset.
REQ-007 in_issue  input  1  fault request; level-sensitive.
REQ-008 in_ped_request  input  NUM_APPROACHES  per-approach pedestrian request; one-clock pulses are sufficient.
REQ-009 out_red_light, out_green_light, out_yellow_light, out_left_turn_light, out_pedestrian_light  output  NUM_APPROACHES each  per-approach lamps, bit i = approach i, registered.
REQ-010 out_active_approach  output  2  index of the approach currently served.
REQ-011 out_phase  output  3  encoding 0 ALL_RED, 1 LEFT, 2 GREEN, 3 YELLOW, 4 FAULT.

Function
REQ-012 The tick prescaler SHALL count 0..CLK_PER_TICK-1 and reload to 0 on every phase entry, so a phase of D ticks lasts exactly D*CLK_PER_TICK clocks.
REQ-013 The FSM SHALL sequence ALL_RED -> LEFT -> GREEN -> YELLOW -> ALL_RED per approach; on exit from ALL_RED (not first after reset or fault), approach SHALL advance as (approach+1) mod NUM_APPROACHES.
REQ-014 Active approach lamps: LEFT = left_turn only; GREEN = green only; YELLOW = yellow only; ALL_RED = red only; all non-active approaches show red only.
REQ-015 Safety invariant: at most one approach SHALL have any of green/yellow/left_turn asserted in any cycle; red and green/yellow/left_turn never both set on one approach.
REQ-016 A pedestrian request SHALL set a sticky per-approach latch; the latch for approach i SHALL clear on the clock GREEN of approach i is exited.
REQ-017 out_pedestrian_light[i] SHALL be 1 during the first PED_TICKS ticks of approach i's GREEN only if its latch was set on GREEN entry; requests for i arriving during i's GREEN are held for its next GREEN (set wins over same-cycle clear).
REQ-018 in_issue = 1 in any non-FAULT phase SHALL force FAULT on the next clock, aborting the current phase.
REQ-019 In FAULT all green/yellow/left_turn/pedestrian lamps SHALL be 0 and all red lamps SHALL toggle together every FLASH_TICKS ticks, starting at 1 on entry.
REQ-020 in_issue = 0 while in FAULT SHALL move to ALL_RED (red steady) for ALL_RED_TICKS, then LEFT of (approach held at fault +1) mod NUM_APPROACHES.
REQ-021 Pedestrian latches SHALL be retained through FAULT and keep accepting requests.

Reset
REQ-022 in_reset = 1 SHALL, on the next rising edge, set phase ALL_RED, approach START_APPROACH, prescaler and phase counter 0, all latches 0.
REQ-023 Reset outputs: out_red_light all 1; green, yellow, left_turn, pedestrian all 0; out_phase 0; out_active_approach START_APPROACH.
REQ-024 Reset SHALL take priority over in_issue and in_ped_request; after release the first ALL_RED SHALL be followed by LEFT of START_APPROACH (no advance).

Configuration
REQ-025 Macro LEFT_TURN_PHASE_EN defined: LEFT phase present as above.
REQ-026 Macro LEFT_TURN_PHASE_EN undefined: LEFT phase skipped (ALL_RED -> GREEN directly), out_left_turn_light tied to 0, out_phase never 1, LEFT_TICKS ignored.

Verification (defaults, LEFT_TURN_PHASE_EN defined)
REQ-027 Reset 3 clocks then release -> red=2'b11 for 4 clocks; approach 0 left 12 clocks, green 20, yellow 8; all red 4; approach 1 left starts clock 48 after release.
REQ-028 Pulse in_ped_request[1] during approach 0 GREEN -> out_pedestrian_light[1] high first 12 clocks of approach 1 GREEN, low thereafter; latch clear after exit.
REQ-029 Raise in_issue mid approach 0 GREEN -> next clock all green/yellow/left 0, red 2'b11 for 8 clocks, 2'b00 for 8, repeating; drop in_issue -> red 2'b11 for 4 clocks, then approach 1 LEFT.
REQ-030 Assert in_reset during approach 1 YELLOW together with in_issue -> reset values next clock, no FAULT entry, restart at approach 0.
REQ-031 NUM_APPROACHES = 3, run 3 full rounds with random ped pulses -> order 0,1,2,0..., REQ-015 never violated (assertion every clock).
REQ-032 Build without LEFT_TURN_PHASE_EN -> after reset ALL_RED 4 clocks then approach 0 GREEN directly; out_left_turn_light constant 0.

Source files
------------

// File: rtl/intersection_phase_controller.sv
// Round-robin intersection phase sequencer with pedestrian latches and a flashing-red fault mode.
// Optional LEFT phase is enabled by defining LEFT_TURN_PHASE_EN.
module intersection_phase_controller #(
    parameter int unsigned NUM_APPROACHES = 2,
    parameter int unsigned CLK_PER_TICK   = 4,
    parameter int unsigned LEFT_TICKS     = 3,
    parameter int unsigned GREEN_TICKS    = 5,
    parameter int unsigned YELLOW_TICKS   = 2,
    parameter int unsigned ALL_RED_TICKS  = 1,
    parameter int unsigned PED_TICKS      = 3,
    parameter int unsigned FLASH_TICKS    = 2,
    parameter int unsigned START_APPROACH = 0
) (
    input  logic                      in_clock,
    input  logic                      in_reset,
    input  logic                      in_issue,
    input  logic [NUM_APPROACHES-1:0] in_ped_request,
    output logic [NUM_APPROACHES-1:0] out_red_light,
    output logic [NUM_APPROACHES-1:0] out_green_light,
    output logic [NUM_APPROACHES-1:0] out_yellow_light,
    output logic [NUM_APPROACHES-1:0] out_left_turn_light,
    output logic [NUM_APPROACHES-1:0] out_pedestrian_light,
    output logic [1:0]                out_active_approach,
    output logic [2:0]                out_phase
);
    localparam int unsigned PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam int unsigned TW = 16;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_TICK - 1);
    localparam logic [1:0]    LAST_APP   = 2'(NUM_APPROACHES - 1);
    localparam logic [1:0]    START_APP  = 2'(START_APPROACH);

    typedef enum logic [2:0] {
        PH_ALL_RED = 3'd0,
        PH_LEFT    = 3'd1,
        PH_GREEN   = 3'd2,
        PH_YELLOW  = 3'd3,
        PH_FAULT   = 3'd4
    } phase_e;

    phase_e                    state_q, state_d;
    logic [1:0]                approach_q, approach_d;
    logic [PW-1:0]             presc_q, presc_d;
    logic [TW-1:0]             tick_q, tick_d;
    logic [TW-1:0]             cur_last;
    logic                      skip_adv_q, skip_adv_d;
    logic                      flash_q, flash_d;
    logic                      serve_q, serve_d;
    logic                      tick_end, phase_done;
    logic [NUM_APPROACHES-1:0] latch_q, latch_d;
    logic [NUM_APPROACHES-1:0] sel_q, sel_d, clr;
    logic [NUM_APPROACHES-1:0] red_q, red_d;
    logic [NUM_APPROACHES-1:0] green_q, green_d;
    logic [NUM_APPROACHES-1:0] yellow_q, yellow_d;
    logic [NUM_APPROACHES-1:0] ped_q, ped_d;
`ifdef LEFT_TURN_PHASE_EN
    logic [NUM_APPROACHES-1:0] left_q, left_d;
`endif

    always_comb begin
        case (state_q)
            PH_ALL_RED: cur_last = TW'(ALL_RED_TICKS - 1);
            PH_LEFT:    cur_last = TW'(LEFT_TICKS - 1);
            PH_GREEN:   cur_last = TW'(GREEN_TICKS - 1);
            PH_YELLOW:  cur_last = TW'(YELLOW_TICKS - 1);
            default:    cur_last = TW'(FLASH_TICKS - 1);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        approach_d = approach_q;
        skip_adv_d = skip_adv_q;
        flash_d    = flash_q;
        serve_d    = serve_q;
        tick_end   = (presc_q == PRESC_LAST);
        phase_done = tick_end && (tick_q == cur_last);
        presc_d    = tick_end ? '0 : presc_q + PW'(1);
        tick_d     = tick_end ? tick_q + TW'(1) : tick_q;

        if (state_q != PH_FAULT && in_issue) begin
            state_d = PH_FAULT;
        end else begin
            case (state_q)
                PH_ALL_RED: if (phase_done) begin
`ifdef LEFT_TURN_PHASE_EN
                    state_d = PH_LEFT;
`else
                    state_d = PH_GREEN;
`endif
                    if (!skip_adv_q)
                        approach_d = (approach_q == LAST_APP) ? 2'd0 : approach_q + 2'd1;
                    skip_adv_d = 1'b0;
                end
                PH_LEFT:   if (phase_done) state_d = PH_GREEN;
                PH_GREEN:  if (phase_done) state_d = PH_YELLOW;
                PH_YELLOW: if (phase_done) state_d = PH_ALL_RED;
                default: begin
                    if (!in_issue) begin
                        state_d = PH_ALL_RED;
                    end else if (phase_done) begin
                        flash_d = ~flash_q;
                        tick_d  = '0;
                    end
                end
            endcase
        end

        if (state_d != state_q) begin
            presc_d = '0;
            tick_d  = '0;
        end
        if (state_d == PH_FAULT && state_q != PH_FAULT)
            flash_d = 1'b1;

        for (int unsigned i = 0; i < NUM_APPROACHES; i++) begin
            sel_q[i] = (approach_q == 2'(i));
            sel_d[i] = (approach_d == 2'(i));
        end

        // Requests always set the latch, so a same-cycle request survives the exit clear.
        clr     = (state_q == PH_GREEN && state_d != PH_GREEN) ? sel_q : '0;
        latch_d = (latch_q & ~clr) | in_ped_request;
        if (state_d == PH_GREEN && state_q != PH_GREEN)
            serve_d = |(latch_d & sel_d);

        red_d    = '0;
        green_d  = '0;
        yellow_d = '0;
        ped_d    = '0;
`ifdef LEFT_TURN_PHASE_EN
        left_d   = '0;
`endif
        for (int unsigned i = 0; i < NUM_APPROACHES; i++) begin
            if (state_d == PH_FAULT) begin
                red_d[i] = flash_d;
            end else if (sel_d[i] && state_d != PH_ALL_RED) begin
                green_d[i]  = (state_d == PH_GREEN);
                yellow_d[i] = (state_d == PH_YELLOW);
`ifdef LEFT_TURN_PHASE_EN
                left_d[i]   = (state_d == PH_LEFT);
`endif
                ped_d[i]    = (state_d == PH_GREEN) && serve_d && (tick_d < TW'(PED_TICKS));
            end else begin
                red_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q    <= PH_ALL_RED;
            approach_q <= START_APP;
            presc_q    <= '0;
            tick_q     <= '0;
            skip_adv_q <= 1'b1;
            flash_q    <= 1'b1;
            serve_q    <= 1'b0;
            latch_q    <= '0;
            red_q      <= '1;
            green_q    <= '0;
            yellow_q   <= '0;
            ped_q      <= '0;
`ifdef LEFT_TURN_PHASE_EN
            left_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            approach_q <= approach_d;
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            skip_adv_q <= skip_adv_d;
            flash_q    <= flash_d;
            serve_q    <= serve_d;
            latch_q    <= latch_d;
            red_q      <= red_d;
            green_q    <= green_d;
            yellow_q   <= yellow_d;
            ped_q      <= ped_d;
`ifdef LEFT_TURN_PHASE_EN
            left_q     <= left_d;
`endif
        end
    end

    assign out_red_light        = red_q;
    assign out_green_light      = green_q;
    assign out_yellow_light     = yellow_q;
    assign out_pedestrian_light = ped_q;
    assign out_active_approach  = approach_q;
    assign out_phase            = state_q;
`ifdef LEFT_TURN_PHASE_EN
    assign out_left_turn_light  = left_q;
`else
    assign out_left_turn_light  = '0;
`endif

endmodule

// File: tb/tb_intersection_phase_controller.sv
// Scoreboard bench for intersection_phase_controller: a clock-count reference model
// predicts every cycle's lamps, phase and approach; a monitor compares at negedge.
module tb_intersection_phase_controller;
    localparam int N   = 3;
    localparam int CPT = 4;
    localparam int LT  = 3;
    localparam int GT  = 5;
    localparam int YT  = 2;
    localparam int AT  = 1;
    localparam int PT  = 3;
    localparam int FT  = 2;
    localparam int SA  = 0;
    localparam int VW  = 5 * N + 5;

    logic         clk = 1'b0;
    logic         rst, iss;
    logic [N-1:0] req;
    logic [N-1:0] red, green, yellow, left, ped;
    logic [1:0]   app;
    logic [2:0]   phase;

    always #5 clk = ~clk;

    intersection_phase_controller #(
        .NUM_APPROACHES(N), .CLK_PER_TICK(CPT), .LEFT_TICKS(LT), .GREEN_TICKS(GT),
        .YELLOW_TICKS(YT), .ALL_RED_TICKS(AT), .PED_TICKS(PT), .FLASH_TICKS(FT),
        .START_APPROACH(SA)
    ) dut (
        .in_clock(clk), .in_reset(rst), .in_issue(iss), .in_ped_request(req),
        .out_red_light(red), .out_green_light(green), .out_yellow_light(yellow),
        .out_left_turn_light(left), .out_pedestrian_light(ped),
        .out_active_approach(app), .out_phase(phase)
    );

    // Model: phase 0 ALL_RED, 1 LEFT, 2 GREEN, 3 YELLOW, 4 FAULT; m_el = clocks since phase entry.
    int           m_phase, m_app, m_el;
    bit           m_first, m_serve;
    bit [N-1:0]   m_latch;
    logic [VW-1:0] exp_q[$];
    int           checks = 0;
    int           fails  = 0;

    function automatic int dur_clk(int ph);
        case (ph)
            0: return AT * CPT;
            1: return LT * CPT;
            2: return GT * CPT;
            3: return YT * CPT;
            default: return 0;
        endcase
    endfunction

    function automatic int succ(int ph);
        case (ph)
`ifdef LEFT_TURN_PHASE_EN
            0: return 1;
`else
            0: return 2;
`endif
            1: return 2;
            2: return 3;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(bit r, bit is, bit [N-1:0] rq);
        int nxt;
        bit [N-1:0] nl;
        if (r) begin
            m_phase = 0; m_app = SA; m_el = 0; m_first = 1; m_serve = 0; m_latch = '0;
            return;
        end
        nl = m_latch | rq;
        if (m_phase != 4 && is)              nxt = 4;
        else if (m_phase == 4)               nxt = is ? 4 : 0;
        else if (m_el + 1 == dur_clk(m_phase)) nxt = succ(m_phase);
        else                                 nxt = m_phase;
        if (nxt != m_phase) begin
            if (m_phase == 2) nl[m_app] = rq[m_app];
            if (m_phase == 0 && nxt != 4) begin
                if (!m_first) m_app = (m_app + 1) % N;
                m_first = 0;
            end
            if (nxt == 2) m_serve = nl[m_app];
            m_el = 0;
        end else begin
            m_el++;
        end
        m_latch = nl;
        m_phase = nxt;
    endtask

    function automatic logic [VW-1:0] model_out();
        logic [N-1:0] r, g, y, l, p;
        r = '0; g = '0; y = '0; l = '0; p = '0;
        for (int i = 0; i < N; i++) begin
            if (m_phase == 4) begin
                r[i] = ((m_el / (FT * CPT)) % 2) == 0;
            end else if (i == m_app && m_phase != 0) begin
                g[i] = (m_phase == 2);
                y[i] = (m_phase == 3);
                l[i] = (m_phase == 1);
                p[i] = (m_phase == 2) && m_serve && (m_el < PT * CPT);
            end else begin
                r[i] = 1'b1;
            end
        end
        return {r, g, y, l, p, 3'(m_phase), 2'(m_app)};
    endfunction

    task automatic drive(bit r, bit is, bit [N-1:0] rq);
        rst = r; iss = is; req = rq;
        model_step(r, is, rq);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(int ph, int ap, int el, int budget);
        int n = 0;
        while (!(m_phase == ph && m_app == ap && m_el == el) && n < budget) begin
            drive(0, 0, '0);
            n++;
        end
        checks++;
        if (n >= budget) begin
            fails++;
            $display("FAIL run_until: phase %0d approach %0d not reached within %0d cycles (model phase %0d approach %0d)",
                     ph, ap, budget, m_phase, m_app);
        end
    endtask

    // Monitor: pops one expectation per clock, plus the lamp safety invariant.
    initial begin
        logic [VW-1:0] exp, act;
        logic [N-1:0]  busy;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act = {red, green, yellow, left, ped, phase, app};
                checks++;
                if (act !== exp) begin
                    fails++;
                    $display("FAIL outputs t=%0t: got r%b g%b y%b l%b p%b ph%0d ap%0d, expected r%b g%b y%b l%b p%b ph%0d ap%0d",
                             $time, red, green, yellow, left, ped, phase, app,
                             exp[VW-1 -: N], exp[VW-1-N -: N], exp[VW-1-2*N -: N],
                             exp[VW-1-3*N -: N], exp[VW-1-4*N -: N], exp[4:2], exp[1:0]);
                end
                busy = green | yellow | left;
                checks++;
                if ($countones(busy) > 1 || (busy & red) != '0) begin
                    fails++;
                    $display("FAIL safety t=%0t: got active %b red %b, required at most one active and no red overlap",
                             $time, busy, red);
                end
            end
        end
    end

    initial begin
        int fault_left = 0;
        bit [N-1:0] rq;
        rst = 1'b1; iss = 1'b0; req = '0;

        repeat (3) drive(1, 0, '0);
        // Timeline from release, plus a pedestrian pulse for approach 1 during approach 0 GREEN.
        for (int c = 0; c < 130; c++) drive(0, 0, (c == 20) ? 3'b010 : 3'b000);

        // Fault mid approach 0 GREEN, then recovery to approach 1.
        run_until(2, 0, 8, 600);
        repeat (40) drive(0, 1, '0);
        repeat (80) drive(0, 0, '0);

        // Reset during approach 1 YELLOW together with a fault request and pedestrian requests.
        run_until(3, 1, 3, 600);
        drive(1, 1, '1);
        repeat (60) drive(0, 0, '0);

        // Random pedestrian pulses and occasional fault episodes over several rounds.
        for (int c = 0; c < 1000; c++) begin
            for (int b = 0; b < N; b++) rq[b] = ($urandom_range(15) == 0);
            if (fault_left == 0 && $urandom_range(399) == 0) fault_left = $urandom_range(40, 5);
            if (fault_left > 0) begin
                drive(0, 1, rq);
                fault_left--;
            end else begin
                drive(0, 0, rq);
            end
        end
        repeat (4) drive(0, 0, '0);

        for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
